// File: rtl/time_counter.sv
// Time-of-day counter: prescaled one-second tick advancing hh:mm:ss plus a
// seconds-since-midnight mirror, with load (range checked) and increment controls.
module time_counter #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    input  logic        load,
    input  logic [4:0]  load_hour,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_sec,
    input  logic        inc_hour,
    input  logic        inc_min,
    output logic [16:0] cur_sec,
    output logic [4:0]  hour,
    output logic [5:0]  min,
    output logic [5:0]  sec,
    output logic        sec_tick,
    output logic        day_wrap,
    output logic        load_err
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [16:0] DAY_LAST = 17'd86399;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre;

    logic        load_ok;
    logic [16:0] load_cs;
    logic [16:0] min_adj_cs;
    logic [16:0] inc_cs;

    // Load validation and the seconds-since-midnight value implied by each control.
    // Increment adjustments use modulo-2^17 offsets; the result is always a valid time.
    always_comb begin
        load_ok    = 1'b0;
        load_cs    = '0;
        min_adj_cs = cur_sec;
        inc_cs     = cur_sec;

        load_ok = (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
        load_cs = 17'(load_hour) * 17'd3600 + 17'(load_min) * 17'd60 + 17'(load_sec);

        if (inc_min) begin
            min_adj_cs = (min == 6'd59) ? (cur_sec - 17'd3540) : (cur_sec + 17'd60);
        end
        inc_cs = min_adj_cs;
        if (inc_hour) begin
            inc_cs = (hour == 5'd23) ? (min_adj_cs - 17'd82800) : (min_adj_cs + 17'd3600);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOP;
            pre      <= '0;
            hour     <= '0;
            min      <= '0;
            sec      <= '0;
            cur_sec  <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;

            case (state)
                STOP: if (run_en)  state <= RUN;
                RUN:  if (!run_en) state <= STOP;
            endcase

            if (load) begin
                if (load_ok) begin
                    hour    <= load_hour;
                    min     <= load_min;
                    sec     <= load_sec;
                    cur_sec <= load_cs;
                    pre     <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (inc_hour || inc_min) begin
                if (inc_min) begin
                    min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                end
                if (inc_hour) begin
                    hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end
                cur_sec <= inc_cs;
                // A terminal count here is held so the tick fires on a later free cycle.
                if (run_en && (pre != PRE_LAST)) begin
                    pre <= pre + PRE_W'(1);
                end
            end else if (run_en) begin
                if (pre == PRE_LAST) begin
                    pre      <= '0;
                    sec_tick <= 1'b1;
                    cur_sec  <= (cur_sec == DAY_LAST) ? 17'd0 : cur_sec + 17'd1;
                    if (sec == 6'd59) begin
                        sec <= '0;
                        if (min == 6'd59) begin
                            min <= '0;
                            if (hour == 5'd23) begin
                                hour     <= '0;
                                day_wrap <= 1'b1;
                            end else begin
                                hour <= hour + 5'd1;
                            end
                        end else begin
                            min <= min + 6'd1;
                        end
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk cycles per second; the bench sets 4.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run_en  input  1  time advances while high.
REQ-005 load  input  1  one-cycle pulse; loads the time fields below.
REQ-006 load_hour  input  5  hour to load, 0..23.
REQ-007 load_min  input  6  minute to load, 0..59.
REQ-008 load_sec  input  6  second to load, 0..59.
REQ-009 inc_hour  input  1  one-cycle pulse; hour +1 mod 24.
REQ-010 inc_min  input  1  one-cycle pulse; minute +1 mod 60.
REQ-011 cur_sec  output  17  seconds since midnight, 0..86399; feeds the hourly chime checker.
REQ-012 hour  output  5  current hour, 0..23.
REQ-013 min  output  6  current minute, 0..59.
REQ-014 sec  output  6  current second, 0..59.
REQ-015 sec_tick  output  1  one-cycle pulse on the cycle the second advances.
REQ-016 day_wrap  output  1  one-cycle pulse when 23:59:59 advances to 00:00:00.
REQ-017 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-018 Prescaler pre, width ceil(log2(CLK_HZ)): increments each cycle while run_en=1; holds its value while run_en=0.
REQ-019 Terminal count: pre=CLK_HZ-1 with run_en=1 and no load or inc pulse gives a tick; pre returns to 0.
REQ-020 On a tick the time advances one second in that same edge; sec_tick=1 for exactly that cycle.
REQ-021 Carry chain: sec 59->0 with min+1; min 59->0 with hour+1; hour 23->0 with day_wrap=1 on the same cycle as sec_tick.
REQ-022 cur_sec is a registered counter kept equal to hour*3600+min*60+sec on every cycle; it wraps from 86399 to 0.
REQ-023 Priority, highest first: rst > load > inc_hour/inc_min > tick.
REQ-024 Valid load (hour<=23, min<=59, sec<=59): next cycle the fields and cur_sec show the loaded time; pre clears to 0; any tick in that cycle is dropped.
REQ-025 Invalid load (any field out of range): time and pre are unchanged; load_err=1 for one cycle.
REQ-026 inc_min: minute +1 mod 60, no carry into hour; sec unchanged; cur_sec adjusted to match.
REQ-027 inc_hour: hour +1 mod 24, no day_wrap; min and sec unchanged.
REQ-028 inc_hour and inc_min in the same cycle: both are applied.
REQ-029 A terminal count that coincides with an inc pulse is deferred: pre holds at CLK_HZ-1 and the tick fires on the next cycle if run_en=1 and no load or inc pulse is present.
REQ-030 Loads and incs take effect regardless of run_en.
REQ-031 Control state machine has two states:
- STOP: run_en=0.
- RUN: run_en=1.
- Transitions follow run_en each cycle.
- Prescaler phase is kept across STOP.
REQ-032 sec_tick, day_wrap and load_err are low on every cycle other than those specified above.
REQ-033 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-034 While rst=1 at a clock edge: pre=0, state=STOP, time=00:00:00, cur_sec=0, sec_tick=0, day_wrap=0, load_err=0.
REQ-035 Reset overrides a simultaneous load or inc; that pulse is lost.
REQ-036 Reset mid-second discards the prescaler phase.
REQ-037 With run_en held at 1 through reset, the first sec_tick comes exactly CLK_HZ cycles after the first edge with rst=0.

Verification (CLK_HZ=4)
REQ-038 Reset, then run_en=1 -> sec_tick on cycles 4, 8, 12 after rst drops; cur_sec reads 1, 2, 3; no other pulses.
REQ-039 Load 23:59:58, run 8 cycles -> cur_sec 86399 after 4 cycles, then 0 with day_wrap=1 on the same cycle as sec_tick.
REQ-040 Load 12:59:59, run -> next tick gives 13:00:00 and cur_sec=46800.
REQ-041 Load hour=24 (or min=60) from 05:06:07 -> load_err pulse; time remains 05:06:07 and cur_sec remains 18367.
REQ-042 At 00:59:30 pulse inc_min -> 00:00:30, cur_sec=30; at 23:10:00 pulse inc_hour -> 00:10:00 with no day_wrap.
REQ-043 Load asserted on a terminal-count cycle -> no sec_tick; pre=0; next tick 4 cycles later. Also: inc on terminal count -> tick 1 cycle late; rst mid-count -> all zero.
